// File: rtl/neural_acq_pkg.sv
// Shared register map, CTRL/STATUS bit positions and capture FSM states
// for the acquisition control/status stage.
package neural_acq_pkg;

    localparam logic [2:0] ADDR_CTRL       = 3'd0;
    localparam logic [2:0] ADDR_STATUS     = 3'd1;
    localparam logic [2:0] ADDR_MASK       = 3'd2;
    localparam logic [2:0] ADDR_BURST_LEN  = 3'd3;
    localparam logic [2:0] ADDR_PKT_COUNT  = 3'd4;
    localparam logic [2:0] ADDR_DROP_COUNT = 3'd5;
    localparam logic [2:0] ADDR_WATERMARK  = 3'd6;
    localparam logic [2:0] ADDR_IRQ_EN     = 3'd7;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_CLR   = 3;

    localparam int STAT_OVF   = 0;
    localparam int STAT_BDONE = 1;
    localparam int STAT_WM    = 2;
    localparam int STAT_FULL  = 3;
    localparam int STAT_BUSY  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_BURST  = 2'd2
    } acq_state_e;

endpackage

// File: rtl/neural_sat_counter.sv
// Saturating up-counter: holds at all ones, clr beats inc.
// One-cycle update latency; no backpressure.
module neural_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/neural_acq_ctrl.sv
// Acquisition CSR block and stream gate between the packet framer and the output FIFO.
// Zero-latency forwarding; no backpressure upstream, packets are dropped while the FIFO is full.
module neural_acq_ctrl
    import neural_acq_pkg::*;
#(
    parameter int PKT_WIDTH    = 64,
    parameter int NUM_CHANNELS = 16,
    parameter int CNT_WIDTH    = 32,
    parameter int LEVEL_WIDTH  = 6
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [PKT_WIDTH-1:0]    in_data,
    input  logic                    in_valid,
    output logic [PKT_WIDTH-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    fifo_full,
    input  logic [LEVEL_WIDTH-1:0]  fifo_level,
    output logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [2:0]              csr_addr,
    input  logic                    csr_write,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    irq
);

    acq_state_e              state_q, state_d;
    logic [1:0]              ctrl_q, ctrl_d;
    logic                    ovf_q, ovf_d, bdone_q, bdone_d, wm_q, wm_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]    burst_len_q, burst_len_d;
    logic [LEVEL_WIDTH-1:0]  wmark_q, wmark_d;
    logic [2:0]              irq_en_q, irq_en_d;
    logic                    irq_q, irq_d;

    logic [CNT_WIDTH-1:0]    pkt_cnt, drop_cnt, burst_cnt;
    logic                    wr_ctrl, start_pulse, clr_pulse, burst_full;
    logic                    gate, fwd, drop, bdone_set, burst_clr;
    logic [2:0]              w1c;

    always_comb begin
        wr_ctrl     = csr_write && (csr_addr == ADDR_CTRL);
        start_pulse = wr_ctrl && csr_wdata[CTRL_START];
        clr_pulse   = wr_ctrl && csr_wdata[CTRL_CLR];
        w1c         = (csr_write && (csr_addr == ADDR_STATUS)) ? csr_wdata[2:0] : 3'b000;
        burst_full  = (burst_cnt >= burst_len_q);
        gate        = (state_q == S_STREAM) || ((state_q == S_BURST) && !burst_full);
        // Reset must mask forwarding even though state_q is still stale during that cycle.
        fwd         = in_valid && gate && !fifo_full && !sys_rst;
        drop        = in_valid && gate && fifo_full && !sys_rst;
    end

    always_comb begin
        state_d   = state_q;
        bdone_set = 1'b0;
        burst_clr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctrl_q[CTRL_EN] && !ctrl_q[CTRL_MODE]) begin
                    state_d = S_STREAM;
                end else if (ctrl_q[CTRL_EN] && ctrl_q[CTRL_MODE] && start_pulse) begin
                    state_d   = S_BURST;
                    burst_clr = 1'b1;
                end
            end
            S_STREAM: begin
                if (!ctrl_q[CTRL_EN] || ctrl_q[CTRL_MODE]) begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = S_IDLE;
                end else if (burst_full) begin
                    state_d   = S_IDLE;
                    bdone_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d      = wr_ctrl ? csr_wdata[1:0] : ctrl_q;
        mask_d      = (csr_write && (csr_addr == ADDR_MASK)) ? csr_wdata[NUM_CHANNELS-1:0] : mask_q;
        burst_len_d = (csr_write && (csr_addr == ADDR_BURST_LEN)) ? csr_wdata[CNT_WIDTH-1:0] : burst_len_q;
        wmark_d     = (csr_write && (csr_addr == ADDR_WATERMARK)) ? csr_wdata[LEVEL_WIDTH-1:0] : wmark_q;
        irq_en_d    = (csr_write && (csr_addr == ADDR_IRQ_EN)) ? csr_wdata[2:0] : irq_en_q;
        // A set event in the same cycle as the W1C write keeps the bit set.
        ovf_d       = (ovf_q & ~w1c[STAT_OVF]) | drop;
        bdone_d     = (bdone_q & ~w1c[STAT_BDONE]) | bdone_set;
        wm_d        = (wm_q & ~w1c[STAT_WM]) | (fifo_level >= wmark_q);
        irq_d       = |({wm_q, bdone_q, ovf_q} & irq_en_q);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            ovf_q       <= 1'b0;
            bdone_q     <= 1'b0;
            wm_q        <= 1'b0;
            mask_q      <= '1;
            burst_len_q <= '0;
            wmark_q     <= '1;
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
            bdone_q     <= bdone_d;
            wm_q        <= wm_d;
            mask_q      <= mask_d;
            burst_len_q <= burst_len_d;
            wmark_q     <= wmark_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
        end
    end

    neural_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk(sys_clk), .rst(sys_rst), .inc(fwd), .clr(clr_pulse), .count(pkt_cnt)
    );

    neural_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk(sys_clk), .rst(sys_rst), .inc(drop), .clr(clr_pulse), .count(drop_cnt)
    );

    neural_sat_counter #(.WIDTH(CNT_WIDTH)) u_burst_cnt (
        .clk(sys_clk), .rst(sys_rst), .inc(fwd && (state_q == S_BURST)), .clr(burst_clr),
        .count(burst_cnt)
    );

    always_comb begin
        csr_rdata = '0;
        unique case (csr_addr)
            ADDR_CTRL:       csr_rdata[1:0] = ctrl_q;
            ADDR_STATUS:     csr_rdata[4:0] = {(state_q != S_IDLE), fifo_full, wm_q, bdone_q, ovf_q};
            ADDR_MASK:       csr_rdata[NUM_CHANNELS-1:0] = mask_q;
            ADDR_BURST_LEN:  csr_rdata[CNT_WIDTH-1:0] = burst_len_q;
            ADDR_PKT_COUNT:  csr_rdata[CNT_WIDTH-1:0] = pkt_cnt;
            ADDR_DROP_COUNT: csr_rdata[CNT_WIDTH-1:0] = drop_cnt;
            ADDR_WATERMARK:  csr_rdata[LEVEL_WIDTH-1:0] = wmark_q;
            ADDR_IRQ_EN:     csr_rdata[2:0] = irq_en_q;
            default:         csr_rdata = '0;
        endcase
    end

    assign out_data     = in_data;
    assign out_valid    = fwd;
    assign channel_mask = mask_q;
    assign irq          = irq_q;

endmodule
